// File: rtl/safe_code_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : safe_code_ctrl
// Purpose  : Keypad code lock with open window, code change and lockout.
// Revision : 1.0 - initial release
// ============================================================================
module safe_code_ctrl #(
    parameter int unsigned CODE_LEN       = 4,
    parameter logic [15:0] DEFAULT_CODE   = 16'h1234,
    parameter int unsigned MAX_FAIL       = 3,
    parameter logic [15:0] UNLOCK_CYCLES  = 16'd50000,
    parameter logic [15:0] LOCKOUT_CYCLES = 16'd60000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] key_code,
    output logic       unlocked,
    output logic       lockout,
    output logic       ok_pulse,
    output logic       err_pulse,
    output logic [2:0] digit_count,
    output logic [1:0] state
);

    localparam logic [1:0] ST_LOCKED  = 2'd0;
    localparam logic [1:0] ST_OPEN    = 2'd1;
    localparam logic [1:0] ST_NEWCODE = 2'd2;
    localparam logic [1:0] ST_LOCKOUT = 2'd3;

    localparam logic [3:0]  KEY_HASH  = 4'd10;
    localparam logic [3:0]  KEY_STAR  = 4'd11;
    localparam logic [2:0]  LEN3      = 3'(CODE_LEN);
    localparam logic [2:0]  MAX3      = 3'(MAX_FAIL);
    localparam logic [15:0] CODE_MASK = (CODE_LEN >= 4) ? 16'hFFFF
                                      : ((16'h1 << (4 * CODE_LEN)) - 16'h1);

    logic [1:0]  state_q, state_d;
    logic [15:0] buf_q, buf_d;
    logic [2:0]  cnt_q, cnt_d;
    logic        ovf_q, ovf_d;
    logic [2:0]  fail_cnt_q, fail_cnt_d;
    logic [15:0] timer_q, timer_d;
    logic [15:0] code_q, code_d;
    logic        ok_q, ok_d;
    logic        err_q, err_d;

    logic        w_is_digit;
    logic        w_hash;
    logic        w_star;
    logic        w_full;
    logic        w_expire;
    logic [15:0] w_timer_dec;
    logic [15:0] w_buf_col;
    logic [2:0]  w_cnt_col;
    logic        w_ovf_col;
    logic [2:0]  w_fail_inc;

    assign w_is_digit  = (key_code < 4'd10);
    assign w_hash      = (key_code == KEY_HASH);
    assign w_star      = (key_code == KEY_STAR);
    assign w_full      = (cnt_q == LEN3);
    // A timed state leaves on the cycle its counter would reach zero.
    assign w_expire    = (timer_q <= 16'd1);
    assign w_timer_dec = (timer_q == 16'd0) ? 16'd0 : timer_q - 16'd1;
    assign w_buf_col   = w_full ? buf_q : ({buf_q[11:0], key_code} & CODE_MASK);
    assign w_cnt_col   = w_full ? cnt_q : cnt_q + 3'd1;
    assign w_ovf_col   = ovf_q | w_full;
    assign w_fail_inc  = (fail_cnt_q < MAX3) ? fail_cnt_q + 3'd1 : fail_cnt_q;

    always_comb begin
        state_d    = state_q;
        buf_d      = buf_q;
        cnt_d      = cnt_q;
        ovf_d      = ovf_q;
        fail_cnt_d = fail_cnt_q;
        timer_d    = timer_q;
        code_d     = code_q;
        ok_d       = 1'b0;
        err_d      = 1'b0;

        case (state_q)
            ST_LOCKED: begin
                if (w_is_digit) begin
                    buf_d = w_buf_col;
                    cnt_d = w_cnt_col;
                    ovf_d = w_ovf_col;
                end else if (w_star) begin
                    buf_d = 16'd0;
                    cnt_d = 3'd0;
                    ovf_d = 1'b0;
                end else if (w_hash && (cnt_q != 3'd0)) begin
                    buf_d = 16'd0;
                    cnt_d = 3'd0;
                    ovf_d = 1'b0;
                    if (w_full && !ovf_q && (buf_q == code_q)) begin
                        state_d    = ST_OPEN;
                        ok_d       = 1'b1;
                        fail_cnt_d = 3'd0;
                        timer_d    = UNLOCK_CYCLES;
                    end else begin
                        err_d      = 1'b1;
                        fail_cnt_d = w_fail_inc;
                        if (w_fail_inc == MAX3) begin
                            state_d = ST_LOCKOUT;
                            timer_d = LOCKOUT_CYCLES;
                        end
                    end
                end
            end

            ST_OPEN: begin
                if (w_expire) begin
                    state_d = ST_LOCKED;
                    timer_d = 16'd0;
                end else begin
                    timer_d = w_timer_dec;
                    if (w_hash) begin
                        state_d = ST_LOCKED;
                        timer_d = 16'd0;
                    end else if (w_star) begin
                        state_d = ST_NEWCODE;
                    end
                end
                buf_d = 16'd0;
                cnt_d = 3'd0;
                ovf_d = 1'b0;
            end

            ST_NEWCODE: begin
                if (w_expire) begin
                    state_d = ST_LOCKED;
                    timer_d = 16'd0;
                    buf_d   = 16'd0;
                    cnt_d   = 3'd0;
                    ovf_d   = 1'b0;
                end else begin
                    timer_d = w_timer_dec;
                    if (w_is_digit) begin
                        buf_d = w_buf_col;
                        cnt_d = w_cnt_col;
                        ovf_d = w_ovf_col;
                    end else if (w_hash || w_star) begin
                        buf_d = 16'd0;
                        cnt_d = 3'd0;
                        ovf_d = 1'b0;
                        if (w_hash && w_full && !ovf_q) begin
                            code_d  = buf_q;
                            ok_d    = 1'b1;
                            state_d = ST_LOCKED;
                            timer_d = 16'd0;
                        end else begin
                            err_d   = w_hash;
                            state_d = ST_OPEN;
                            timer_d = UNLOCK_CYCLES;
                        end
                    end
                end
            end

            default: begin
                if (w_expire) begin
                    state_d    = ST_LOCKED;
                    fail_cnt_d = 3'd0;
                    timer_d    = 16'd0;
                end else begin
                    timer_d = w_timer_dec;
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_LOCKED;
            buf_q      <= 16'd0;
            cnt_q      <= 3'd0;
            ovf_q      <= 1'b0;
            fail_cnt_q <= 3'd0;
            timer_q    <= 16'd0;
            code_q     <= DEFAULT_CODE & CODE_MASK;
            ok_q       <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            buf_q      <= buf_d;
            cnt_q      <= cnt_d;
            ovf_q      <= ovf_d;
            fail_cnt_q <= fail_cnt_d;
            timer_q    <= timer_d;
            code_q     <= code_d;
            ok_q       <= ok_d;
            err_q      <= err_d;
        end
    end

    assign unlocked    = (state_q == ST_OPEN) || (state_q == ST_NEWCODE);
    assign lockout     = (state_q == ST_LOCKOUT);
    assign ok_pulse    = ok_q;
    assign err_pulse   = err_q;
    assign digit_count = cnt_q;
    assign state       = state_q;

endmodule
`default_nettype wire

// File: tb/tb_safe_code_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_safe_code_ctrl
// Purpose  : Directed and random checks of safe_code_ctrl against a queue model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_safe_code_ctrl;

    localparam int UNLOCK  = 20;
    localparam int LOCKOUT = 40;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] key_code = 4'd13;
    logic       unlocked, lockout, ok_pulse, err_pulse;
    logic [2:0] digit_count;
    logic [1:0] state;

    int n_tests = 0;
    int n_fail  = 0;

    // Model: 0 LOCKED, 1 OPEN, 2 NEWCODE, 3 LOCKOUT; m_left = cycles left in a timed state
    int m_st;
    int m_entry[$];
    int m_code[$];
    bit m_ovf;
    int m_fail;
    int m_left;
    bit m_ok, m_err;

    safe_code_ctrl #(
        .CODE_LEN       (4),
        .DEFAULT_CODE   (16'h1234),
        .MAX_FAIL       (3),
        .UNLOCK_CYCLES  (16'(UNLOCK)),
        .LOCKOUT_CYCLES (16'(LOCKOUT))
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .key_code    (key_code),
        .unlocked    (unlocked),
        .lockout     (lockout),
        .ok_pulse    (ok_pulse),
        .err_pulse   (err_pulse),
        .digit_count (digit_count),
        .state       (state)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic void model_reset();
        m_st = 0;
        m_entry.delete();
        m_code = '{1, 2, 3, 4};
        m_ovf = 0; m_fail = 0; m_left = 0; m_ok = 0; m_err = 0;
    endfunction

    function automatic void clear_entry();
        m_entry.delete();
        m_ovf = 0;
    endfunction

    function automatic void add_digit(input int d);
        if (m_entry.size() < 4) m_entry.push_back(d);
        else m_ovf = 1;
    endfunction

    function automatic bit entry_matches();
        if (m_entry.size() != m_code.size()) return 0;
        foreach (m_entry[i]) if (m_entry[i] != m_code[i]) return 0;
        return 1;
    endfunction

    function automatic void model_step(input int k);
        m_ok = 0; m_err = 0;
        if (m_st != 0) begin
            m_left--;
            if (m_left == 0) begin
                if (m_st == 3) m_fail = 0;
                m_st = 0;
                clear_entry();
                return;
            end
        end
        case (m_st)
            0: begin
                if (k <= 9) add_digit(k);
                else if (k == 11) clear_entry();
                else if (k == 10 && m_entry.size() != 0) begin
                    if (!m_ovf && entry_matches()) begin
                        m_st = 1; m_ok = 1; m_fail = 0; m_left = UNLOCK;
                    end else begin
                        m_err = 1;
                        m_fail++;
                        if (m_fail == 3) begin m_st = 3; m_left = LOCKOUT; end
                    end
                    clear_entry();
                end
            end
            1: begin
                if (k == 10) m_st = 0;
                else if (k == 11) begin m_st = 2; clear_entry(); end
            end
            2: begin
                if (k <= 9) add_digit(k);
                else if (k == 10) begin
                    if (!m_ovf && m_entry.size() == 4) begin
                        m_code = m_entry;
                        m_ok = 1; m_st = 0;
                    end else begin
                        m_err = 1; m_st = 1; m_left = UNLOCK;
                    end
                    clear_entry();
                end else if (k == 11) begin
                    m_st = 1; m_left = UNLOCK; clear_entry();
                end
            end
            default: ;
        endcase
    endfunction

    task automatic compare_all(input string pfx);
        chk({pfx, ".state"},    32'(state),       32'(m_st));
        chk({pfx, ".unlocked"}, 32'(unlocked),    32'(m_st == 1 || m_st == 2));
        chk({pfx, ".lockout"},  32'(lockout),     32'(m_st == 3));
        chk({pfx, ".ok"},       32'(ok_pulse),    32'(m_ok));
        chk({pfx, ".err"},      32'(err_pulse),   32'(m_err));
        chk({pfx, ".count"},    32'(digit_count), 32'(m_entry.size()));
        chk({pfx, ".fail"},     32'(dut.fail_cnt_q), 32'(m_fail));
    endtask

    task automatic cycle(input int k);
        @(negedge clk);
        key_code = 4'(k);
        model_step(k);
        @(posedge clk);
        #1;
        compare_all("cyc");
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(13);
    endtask

    task automatic enter4(input int a, input int b, input int c, input int d);
        cycle(a); cycle(b); cycle(c); cycle(d); cycle(10);
    endtask

    task automatic do_reset();
        @(negedge clk);
        key_code = 4'd13;
        rst = 1'b1;
        model_reset();
        #1;
        compare_all("rst");
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        model_reset();
        do_reset();

        // Unlock and auto-relock after the open window
        enter4(1, 2, 3, 4);
        chk("r38_ok", 32'(ok_pulse), 1);
        chk("r38_unl", 32'(unlocked), 1);
        chk("r38_st", 32'(state), 1);
        idle(UNLOCK - 1);
        chk("r38_still_open", 32'(state), 1);
        idle(1);
        chk("r38_relock_st", 32'(state), 0);
        chk("r38_relock_unl", 32'(unlocked), 0);

        // Three failures lead to lockout; digits ignored throughout
        for (int t = 0; t < 3; t++) begin
            enter4(9, 9, 9, 9);
            chk("r39_err", 32'(err_pulse), 1);
        end
        chk("r39_lockout", 32'(lockout), 1);
        chk("r39_st", 32'(state), 3);
        for (int i = 0; i < LOCKOUT - 1; i++) cycle(i % 10);
        chk("r39_still_lock", 32'(state), 3);
        idle(1);
        chk("r39_free", 32'(state), 0);
        enter4(1, 2, 3, 4);
        chk("r39_unlock", 32'(ok_pulse), 1);
        cycle(10);

        // Overflowed entry fails; star discards a partial entry
        cycle(1); cycle(2); cycle(3); cycle(4); cycle(5);
        chk("r40_cnt4", 32'(digit_count), 4);
        cycle(10);
        chk("r40_err", 32'(err_pulse), 1);
        chk("r40_cnt0", 32'(digit_count), 0);
        chk("r40_fail1", 32'(dut.fail_cnt_q), 1);
        cycle(1); cycle(11);
        enter4(1, 2, 3, 4);
        chk("r40_ok", 32'(ok_pulse), 1);

        // Short new code is rejected and code is kept
        cycle(11); cycle(5); cycle(6); cycle(10);
        chk("r42_err", 32'(err_pulse), 1);
        chk("r42_st", 32'(state), 1);
        cycle(10);
        enter4(1, 2, 3, 4);
        chk("r42_code_kept", 32'(ok_pulse), 1);

        // Code change to 5678
        cycle(11);
        enter4(5, 6, 7, 8);
        chk("r41_ok", 32'(ok_pulse), 1);
        chk("r41_st", 32'(state), 0);
        enter4(1, 2, 3, 4);
        chk("r41_old_err", 32'(err_pulse), 1);
        enter4(5, 6, 7, 8);
        chk("r41_new_unl", 32'(unlocked), 1);

        // Asynchronous reset mid-OPEN restores the default code
        do_reset();
        chk("r43_unl0", 32'(unlocked), 0);
        enter4(1, 2, 3, 4);
        chk("r43_ok", 32'(ok_pulse), 1);

        // Random traffic against the model
        for (int it = 0; it < 500; it++) begin
            int r;
            int c[4];
            r = int'($urandom_range(0, 19));
            if (r < 5) begin
                foreach (c[i]) c[i] = m_code[i];
                enter4(c[0], c[1], c[2], c[3]);
            end else if (r == 5) begin
                cycle(11);
                for (int i = 0; i < int'($urandom_range(2, 5)); i++)
                    cycle(int'($urandom_range(0, 9)));
                cycle(10);
            end else if (r == 6 && $urandom_range(0, 9) == 0) begin
                do_reset();
            end else if (r == 7) begin
                idle(int'($urandom_range(1, 25)));
            end else begin
                cycle(int'($urandom_range(0, 15)));
            end
            chk("pulse_excl", 32'(ok_pulse & err_pulse), 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
